// File: rtl/tx_iq_pkg.sv
// Shared types and helpers for the TX IQ buffer: default sample width,
// buffer state enumeration and the occupancy-counter width.
package tx_iq_pkg;

  localparam int unsigned IQ_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_RUN
  } tx_state_e;

  // Occupancy runs 0..DEPTH inclusive, so one bit more than the pointer width.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and synchronous flush.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module iq_sync_fifo
  import tx_iq_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * IQ_WIDTH_DEF,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [lvl_width(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tx_iq_buffer.sv
// TX IQ elastic buffer: captures bus-side IQ pairs on tx_iq_valid rising edges
// and releases one pair per sample_strobe once the prefill threshold is met.
module tx_iq_buffer
  import tx_iq_pkg::*;
#(
  parameter int unsigned IQ_WIDTH = IQ_WIDTH_DEF,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PREFILL  = 8
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        tx,
  input  logic signed [IQ_WIDTH-1:0]  TX_I,
  input  logic signed [IQ_WIDTH-1:0]  TX_Q,
  input  logic                        tx_iq_valid,
  input  logic                        sample_strobe,
  input  logic                        status_clear,
  output logic signed [IQ_WIDTH-1:0]  out_I,
  output logic signed [IQ_WIDTH-1:0]  out_Q,
  output logic                        out_valid,
  output logic [lvl_width(DEPTH)-1:0] fifo_level,
  output logic                        overflow,
  output logic                        underrun
);

  localparam int unsigned   LW          = lvl_width(DEPTH);
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

  tx_state_e                  state_q, state_d;
  logic                       valid_q, tx_q;
  logic signed [IQ_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                       out_valid_q;
  logic                       overflow_q, overflow_d, underrun_q, underrun_d;
  logic                       push, pop, flush, full, empty, ovf_set, und_set;
  logic [2*IQ_WIDTH-1:0]      head;
  logic [LW-1:0]              level, level_after_push;

  iq_sync_fifo #(
    .WIDTH (2 * IQ_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({TX_I, TX_Q}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    flush   = ~tx;
    // ~tx_q with tx already required is the "tx rising" qualifier from IDLE.
    push    = tx_iq_valid & ~valid_q & tx & ((state_q != ST_IDLE) | ~tx_q);
    pop     = tx & sample_strobe & (state_q == ST_RUN) & ~empty;
    und_set = tx & sample_strobe & (state_q == ST_RUN) & empty;
    ovf_set = push & full & ~pop;
    level_after_push = level + LW'(push & ~full);

    state_d = state_q;
    if (!tx) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_PREFILL;
        ST_PREFILL: if (level_after_push >= PREFILL_LVL) state_d = ST_RUN;
        ST_RUN:     if (und_set) state_d = ST_PREFILL;
        default:    state_d = ST_IDLE;
      endcase
    end

    out_i_d = out_i_q;
    out_q_d = out_q_q;
    if (pop) begin
      {out_i_d, out_q_d} = head;
    end else if (sample_strobe) begin
      out_i_d = '0;
      out_q_d = '0;
    end

    overflow_d = ovf_set | (overflow_q & ~status_clear);
    underrun_d = und_set | (underrun_q & ~status_clear);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b1;
      tx_q        <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= tx_iq_valid;
      tx_q        <= tx;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= sample_strobe;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_I      = out_i_q;
  assign out_Q      = out_q_q;
  assign out_valid  = out_valid_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_iq_buffer.sv
// Self-checking bench for tx_iq_buffer: directed scenarios plus a random phase,
// all compared every cycle against a queue-based reference model.
module tb_tx_iq_buffer;

  localparam int unsigned IQW     = 32;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PREFILL = 8;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic                   clk_in = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   tx = 1'b0;
  logic                   tx_iq_valid = 1'b0;
  logic                   sample_strobe = 1'b0;
  logic                   status_clear = 1'b0;
  logic signed [IQW-1:0]  TX_I = '0;
  logic signed [IQW-1:0]  TX_Q = '0;
  logic signed [IQW-1:0]  out_I, out_Q;
  logic                   out_valid;
  logic [LW-1:0]          fifo_level;
  logic                   overflow, underrun;

  always #5 clk_in = ~clk_in;

  tx_iq_buffer #(
    .IQ_WIDTH (IQW),
    .DEPTH    (DEPTH),
    .PREFILL  (PREFILL)
  ) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .tx            (tx),
    .TX_I          (TX_I),
    .TX_Q          (TX_Q),
    .tx_iq_valid   (tx_iq_valid),
    .sample_strobe (sample_strobe),
    .status_clear  (status_clear),
    .out_I         (out_I),
    .out_Q         (out_Q),
    .out_valid     (out_valid),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  // Reference model: a queue of pending pairs plus a "streaming" flag.
  logic [2*IQW-1:0]      m_q[$];
  bit                    m_run, m_vprev, m_txprev, m_ovf, m_und, m_oval;
  logic signed [IQW-1:0] m_oi, m_oq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int period = 0;
  bit force_strobe = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run = 1'b0; m_vprev = 1'b1; m_txprev = 1'b0;
    m_ovf = 1'b0; m_und = 1'b0; m_oval = 1'b0;
    m_oi = '0; m_oq = '0;
  endtask

  task automatic model_step();
    bit was_run, rise, ovf_set, und_set;
    was_run = m_run;
    rise    = tx_iq_valid & ~m_vprev;
    ovf_set = 1'b0;
    und_set = 1'b0;
    m_oval  = sample_strobe;
    if (!tx) begin
      m_q.delete();
      m_run = 1'b0;
      if (sample_strobe) begin m_oi = '0; m_oq = '0; end
    end else begin
      if (sample_strobe) begin
        if (was_run && m_q.size() > 0) begin
          {m_oi, m_oq} = m_q.pop_front();
        end else begin
          m_oi = '0; m_oq = '0;
          if (was_run) begin und_set = 1'b1; m_run = 1'b0; end
        end
      end
      if (rise) begin
        if (m_q.size() < DEPTH) m_q.push_back({TX_I, TX_Q});
        else ovf_set = 1'b1;
      end
      if (!was_run && m_txprev && m_q.size() >= PREFILL) m_run = 1'b1;
    end
    m_ovf    = ovf_set | (m_ovf & ~status_clear);
    m_und    = und_set | (m_und & ~status_clear);
    m_vprev  = tx_iq_valid;
    m_txprev = tx;
  endtask

  task automatic tick();
    sample_strobe = force_strobe | (period != 0 && (cyc % period) == 0);
    if (reset_n) model_step(); else model_reset();
    @(posedge clk_in);
    #1;
    cyc++;
    check_eq("out_valid", out_valid, m_oval);
    check_eq("out_I", out_I, m_oi);
    check_eq("out_Q", out_Q, m_oq);
    check_eq("fifo_level", fifo_level, m_q.size());
    check_eq("overflow", overflow, m_ovf);
    check_eq("underrun", underrun, m_und);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_sample(input logic signed [IQW-1:0] i_val, input logic signed [IQW-1:0] q_val);
    TX_I = i_val;
    TX_Q = q_val;
    tx_iq_valid = 1'b1;
    run(2);
    tx_iq_valid = 1'b0;
    run(2);
  endtask

  initial begin
    model_reset();
    // Reset with tx and tx_iq_valid already high: release must not push.
    tx = 1'b1;
    tx_iq_valid = 1'b1;
    run(3);
    reset_n = 1'b1;
    run(5);
    check_eq("no_push_at_release", fifo_level, 0);
    tx_iq_valid = 1'b0;
    run(2);

    // Prefill with I=k, Q=-k, strobe every 20 cycles, drain into underrun.
    period = 20;
    for (int k = 1; k <= 8; k++) push_sample(k, -k);
    run(200);
    check_eq("underrun_after_drain", underrun, 1);
    check_eq("level_after_drain", fifo_level, 0);

    period = 0;
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    check_eq("underrun_cleared", underrun, 0);

    // Overflow: 17 edges without strobes.
    for (int k = 1; k <= 17; k++) push_sample(100 + k, -(100 + k));
    check_eq("ovf_level", fifo_level, 16);
    check_eq("ovf_flag", overflow, 1);

    // Full FIFO: push and pop in the same cycle.
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    TX_I = 999; TX_Q = -999;
    tx_iq_valid = 1'b1; force_strobe = 1'b1;
    tick();
    force_strobe = 1'b0;
    tick();
    tx_iq_valid = 1'b0;
    check_eq("full_pushpop_level", fifo_level, 16);
    check_eq("full_pushpop_no_ovf", overflow, 0);
    period = 5;
    run(100);

    // tx drop with level 5.
    period = 0;
    for (int k = 1; k <= 5; k++) push_sample(200 + k, 300 + k);
    check_eq("pre_drop_level", fifo_level, 5);
    tx = 1'b0;
    tick();
    check_eq("drop_level", fifo_level, 0);
    period = 7;
    run(30);
    check_eq("drop_sticky_und", underrun, 1);
    period = 0;
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    check_eq("clear_und", underrun, 0);
    check_eq("clear_ovf", overflow, 0);

    // Asynchronous reset in the middle of RUN.
    tx = 1'b1;
    run(2);
    for (int k = 1; k <= 8; k++) push_sample(32'h55 + k, 32'h77 + k);
    force_strobe = 1'b1; tick(); force_strobe = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_out_I", out_I, 0);
    check_eq("rst_out_Q", out_Q, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_flags", {overflow, underrun}, 0);
    model_reset();
    run(2);
    reset_n = 1'b1;
    run(3);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      tx = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, (n < 1000) ? 2 : 1) == 0) tx_iq_valid = ~tx_iq_valid;
      TX_I = $urandom;
      TX_Q = $urandom;
      force_strobe = ($urandom_range(0, 4) == 0);
      status_clear = ($urandom_range(0, 39) == 0);
      tick();
    end
    force_strobe = 1'b0;
    status_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_iq_buffer.md
Name: tx_iq_buffer

Overview:
- Sits directly downstream of the STM32 bus interface on the TX path. It takes the bursty TX_I/TX_Q words, which are qualified by the level-type tx_iq_valid, and stores them in a small FIFO.
- It releases one IQ pair per sample_strobe to the TX interpolator/NCO chain at a fixed rate.
- It absorbs bus jitter with a prefill threshold, inserts zeros on underrun, and reports level/overflow/underrun back for the SEND PARAMS status bytes.

Parameters:
- IQ_WIDTH, 32, width of each of I and Q (signed).
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- PREFILL, 8, entries required before output starts; 1 <= PREFILL <= DEPTH.

Ports:
- clk_in  in  1  system clock (same clock as the bus interface)
- reset_n  in  1  asynchronous active-low reset
- tx  in  1  transmit enable from the parameter register
- TX_I  in  IQ_WIDTH  signed I word from the bus interface
- TX_Q  in  IQ_WIDTH  signed Q word from the bus interface
- tx_iq_valid  in  1  level flag; a rising edge means a new TX_I/TX_Q pair is stable
- sample_strobe  in  1  one-cycle pulse at the TX sample rate, from the interpolator
- status_clear  in  1  one-cycle pulse; clears the sticky flags
- out_I  out  IQ_WIDTH  signed I to the interpolator
- out_Q  out  IQ_WIDTH  signed Q to the interpolator
- out_valid  out  1  one-cycle pulse qualifying out_I/out_Q
- fifo_level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- underrun  out  1  sticky: a zero was substituted in RUN

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - out_I=0, out_Q=0, out_valid=0, fifo_level=0, overflow=0, underrun=0.
  - State=IDLE, pointers=0.
  - The edge-detect register for tx_iq_valid resets to 1, so a high level at reset release does not create a push.
- Push:
  - push = tx_iq_valid & ~valid_d & tx & (state != IDLE or tx rising this cycle).
  - Data is sampled in the same cycle as the edge.
- States:
  - IDLE:
    - tx=0. FIFO is held flushed (both pointers 0, level 0).
    - On each sample_strobe, out_I/out_Q are driven to 0 and out_valid is pulsed.
    - On tx=1, go to PREFILL.
  - PREFILL:
    - Pushes are accepted; no pops.
    - Each sample_strobe outputs zeros with out_valid.
    - When level >= PREFILL (evaluated after this cycle's push), go to RUN next cycle.
  - RUN:
    - On sample_strobe with level>0: pop the head; out_I/out_Q are registered; out_valid=1 the following cycle (latency 1).
    - On sample_strobe with level=0: output zeros with out_valid, set underrun, go to PREFILL.
  - From any state, tx=0 goes to IDLE next cycle and flushes the FIFO. Sticky flags are not cleared by tx.
- Simultaneous push and pop: both take effect, level unchanged. This is legal even when full, since the pop frees a slot first.
- Push when full without a pop: the sample is dropped, overflow is set, and pointers/level are unchanged.
- Pointers wrap modulo DEPTH. fifo_level is an explicit counter, never derived from pointer difference alone.
- status_clear clears overflow/underrun. If a set event occurs in the same cycle, the set wins.
- out_I/out_Q hold their last value between strobes; out_valid is high for exactly one cycle per sample_strobe, in every state.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package tx_iq_pkg: IQ_WIDTH default, state enumeration (IDLE, PREFILL, RUN), level width function.
- Sub-module iq_sync_fifo: single-clock, 2*IQ_WIDTH wide, DEPTH entries, with push/pop/full/empty/level.
- The FSM, edge detect and sticky flags stay in tx_iq_buffer.

Test Plan:
- Prefill and start:
  - Stimulus: reset, tx=1, 8 tx_iq_valid edges with I=1..8, Q=-1..-8, sample_strobe every 20 cycles.
  - Response: zeros with out_valid until level reaches 8, then out_I=1, out_Q=-1 one cycle after the next strobe, in order.
- Underrun:
  - Stimulus: after the 8 samples drain, one more sample_strobe.
  - Response: out_I=out_Q=0, out_valid=1, underrun=1, state returns to PREFILL.
- Overflow:
  - Stimulus: tx=1, no strobes, 17 edges.
  - Response: fifo_level=16, overflow=1, the 17th sample is absent when draining.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, edge and strobe in the same cycle.
  - Response: level stays 16, no overflow, the new sample appears last.
- tx drop mid-stream:
  - Stimulus: level=5, tx->0.
  - Response: next cycle level=0, later strobes output zeros, sticky flags retained.
  - Stimulus: status_clear.
  - Response: flags cleared.
- Reset edge cases:
  - Stimulus: tx_iq_valid held high across reset release.
  - Response: no push.
  - Stimulus: reset asserted mid-RUN.
  - Response: all outputs 0 immediately.
